// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-ported Data_Memory.
// One command is in flight at a time; IDLE -> ACCESS (-> RESP for loads) -> IDLE.
// Build option: define DMEM_ARB_FIXED_PRIORITY_EN to make requester 0 always win
// contention; otherwise requesters alternate round-robin under contention.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     req0_valid,
  input  logic                     req0_write,
  input  logic [ADDRESS_WIDTH-1:0] req0_address,
  input  logic [DATA_WIDTH-1:0]    req0_wdata,
  output logic                     req0_ready,

  input  logic                     req1_valid,
  input  logic                     req1_write,
  input  logic [ADDRESS_WIDTH-1:0] req1_address,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     req1_ready,

  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_rdata,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_rdata,

  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic                     mem_Write_Enable,
  output logic [DATA_WIDTH-1:0]    mem_DATA_WRITE,
  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  output logic                     mem_Read_Enable,
  input  logic [DATA_WIDTH-1:0]    mem_DATA_READ
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                   state_q;
  logic                     grant_id_q;  // 0 = requester 0, 1 = requester 1
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     mem_we_q;
  logic                     mem_re_q;
  logic                     rsp0_valid_q;
  logic                     rsp1_valid_q;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
  logic                     last_grant_q;  // requester granted most recently
`endif

  logic                     win0;
  logic                     win1;
  logic                     idle;
  logic                     accept;
  logic                     acc_id;
  logic                     acc_write;
  logic [ADDRESS_WIDTH-1:0] acc_address;
  logic [DATA_WIDTH-1:0]    acc_wdata;

  // Arbitration: pick at most one winner among the valid requesters.
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    win0 = req0_valid;
    win1 = req1_valid & ~req0_valid;
`else
    if (req0_valid && req1_valid) begin
      // Grant whoever was not served last.
      win0 = last_grant_q;
      win1 = ~last_grant_q;
    end else begin
      win0 = req0_valid;
      win1 = req1_valid;
    end
`endif
  end

  // Ready is offered only in IDLE; reset masks it so every output is 0 during reset.
  always_comb begin
    idle        = (state_q == StIdle) && !reset;
    req0_ready  = idle & win0;
    req1_ready  = idle & win1;
    accept      = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    acc_id      = req1_ready;
    acc_write   = acc_id ? req1_write   : req0_write;
    acc_address = acc_id ? req1_address : req0_address;
    acc_wdata   = acc_id ? req1_wdata   : req0_wdata;
  end

  // Control FSM with registered memory enables and response strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_id_q   <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= '0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            grant_id_q <= acc_id;
            write_q    <= acc_write;
            address_q  <= acc_address;
            wdata_q    <= acc_wdata;
            mem_we_q   <= acc_write;
            mem_re_q   <= ~acc_write;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
            last_grant_q <= acc_id;
`endif
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          mem_we_q <= 1'b0;
          mem_re_q <= 1'b0;
          if (write_q) begin
            state_q <= StIdle;
          end else begin
            // Read data appears on mem_DATA_READ during RESP.
            rsp0_valid_q <= ~grant_id_q;
            rsp1_valid_q <= grant_id_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          mem_we_q     <= 1'b0;
          mem_re_q     <= 1'b0;
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  // Memory ports carry the latched command; responses forward the memory read data.
  always_comb begin
    mem_write_address = address_q;
    mem_DATA_WRITE    = wdata_q;
    mem_read_address  = address_q;
    mem_Write_Enable  = mem_we_q;
    mem_Read_Enable   = mem_re_q;
    rsp0_valid        = rsp0_valid_q;
    rsp1_valid        = rsp1_valid_q;
    rsp0_rdata        = rsp0_valid_q ? mem_DATA_READ : '0;
    rsp1_rdata        = rsp1_valid_q ? mem_DATA_READ : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven single-requester vectors,
// a response scoreboard, and hand-written contention/backpressure/reset sequences.
module tb_dmem_arbiter;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_write, req1_valid, req1_write;
  logic [AW-1:0] req0_address, req1_address;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] mem_write_address, mem_read_address;
  logic          mem_Write_Enable, mem_Read_Enable;
  logic [DW-1:0] mem_DATA_WRITE, mem_DATA_READ;

  always #5 clock = ~clock;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clock             (clock),
    .reset             (reset),
    .req0_valid        (req0_valid),
    .req0_write        (req0_write),
    .req0_address      (req0_address),
    .req0_wdata        (req0_wdata),
    .req0_ready        (req0_ready),
    .req1_valid        (req1_valid),
    .req1_write        (req1_write),
    .req1_address      (req1_address),
    .req1_wdata        (req1_wdata),
    .req1_ready        (req1_ready),
    .rsp0_valid        (rsp0_valid),
    .rsp0_rdata        (rsp0_rdata),
    .rsp1_valid        (rsp1_valid),
    .rsp1_rdata        (rsp1_rdata),
    .mem_write_address (mem_write_address),
    .mem_Write_Enable  (mem_Write_Enable),
    .mem_DATA_WRITE    (mem_DATA_WRITE),
    .mem_read_address  (mem_read_address),
    .mem_Read_Enable   (mem_Read_Enable),
    .mem_DATA_READ     (mem_DATA_READ)
  );

  // Data_Memory model: synchronous write, registered read.
  logic [DW-1:0] sim_mem [16];
  always @(posedge clock) begin
    if (mem_Write_Enable) sim_mem[mem_write_address] <= mem_DATA_WRITE;
    if (mem_Read_Enable)  mem_DATA_READ <= sim_mem[mem_read_address];
  end

  typedef struct {
    bit            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
  } rsp_t;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cmd_t q0[$];
  cmd_t q1[$];
  rsp_t exp_q[$];
  bit   grant_log[$];

  // Reference model state; m_state describes the DUT state at the current negedge.
  logic [DW-1:0] model_mem [16];
  int            m_state = 0;  // 0 idle, 1 access, 2 resp
  bit            m_wr, m_id;
  bit            m_last = 1'b1;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            acc0 = 1'b0, acc1 = 1'b0;
  bit            last_rsp_id;
  logic [DW-1:0] last_rsp_data;
  logic [AW-1:0] last_we_addr;
  logic [DW-1:0] last_we_data;
  int            rsp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_Write_Enable,
                   mem_Read_Enable, rsp0_rdata, rsp1_rdata, mem_write_address,
                   mem_read_address, mem_DATA_WRITE}), 64'd0);
  endtask

  // Monitor / scoreboard: compares DUT outputs against the reference model each negedge.
  always @(negedge clock) begin
    bit   e0, e1, v0, v1;
    rsp_t r;
    if (reset) begin
      m_state = 0;
      m_last  = 1'b1;
      acc0    = 1'b0;
      acc1    = 1'b0;
      exp_q.delete();
    end else begin
      v0 = req0_valid;
      v1 = req1_valid;
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      e0 = v0;
      e1 = v1 && !v0;
`else
      if (v0 && v1) begin
        e0 = m_last;
        e1 = !m_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
`endif
      if (m_state != 0) begin
        e0 = 1'b0;
        e1 = 1'b0;
      end
      chk("req0_ready", 64'(req0_ready), 64'(e0));
      chk("req1_ready", 64'(req1_ready), 64'(e1));
      chk("mem_we", 64'(mem_Write_Enable), 64'(m_state == 1 && m_wr));
      chk("mem_re", 64'(mem_Read_Enable), 64'(m_state == 1 && !m_wr));
      if (m_state == 1 && m_wr) begin
        chk("wr_addr", 64'(mem_write_address), 64'(m_addr));
        chk("wr_data", 64'(mem_DATA_WRITE), 64'(m_wdata));
      end
      if (m_state == 1 && !m_wr) chk("rd_addr", 64'(mem_read_address), 64'(m_addr));
      if (mem_Write_Enable) begin
        last_we_addr = mem_write_address;
        last_we_data = mem_DATA_WRITE;
      end
      chk("rsp0_valid", 64'(rsp0_valid), 64'(m_state == 2 && !m_id));
      chk("rsp1_valid", 64'(rsp1_valid), 64'(m_state == 2 && m_id));
      if (rsp0_valid || rsp1_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          r = exp_q.pop_front();
          chk("rsp_id", 64'(rsp1_valid), 64'(r.id));
          chk("rsp_rdata", 64'(rsp1_valid ? rsp1_rdata : rsp0_rdata), 64'(r.data));
          last_rsp_id   = rsp1_valid;
          last_rsp_data = rsp1_valid ? rsp1_rdata : rsp0_rdata;
        end
      end
      acc0 = v0 && req0_ready;
      acc1 = v1 && req1_ready;
      // Advance the model to the state after the coming posedge.
      case (m_state)
        1: m_state = m_wr ? 0 : 2;
        2: m_state = 0;
        default: begin
          if ((v0 && e0) || (v1 && e1)) begin
            m_id    = e1;
            m_wr    = e1 ? req1_write   : req0_write;
            m_addr  = e1 ? req1_address : req0_address;
            m_wdata = e1 ? req1_wdata   : req0_wdata;
            if (m_wr) model_mem[m_addr] = m_wdata;
            else exp_q.push_back('{id: m_id, data: model_mem[m_addr]});
            grant_log.push_back(m_id);
            m_last  = m_id;
            m_state = 1;
          end
        end
      endcase
    end
  end

  // Requester 0 driver: holds each command valid until accepted.
  initial begin
    cmd_t c;
    req0_valid = 1'b0; req0_write = 1'b0; req0_address = '0; req0_wdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) req0_valid = 1'b0;
      else begin
        if (acc0) req0_valid = 1'b0;
        if (!req0_valid && q0.size() > 0) begin
          c = q0.pop_front();
          req0_write = c.wr; req0_address = c.addr; req0_wdata = c.wdata;
          req0_valid = 1'b1;
        end
      end
    end
  end

  // Requester 1 driver.
  initial begin
    cmd_t c;
    req1_valid = 1'b0; req1_write = 1'b0; req1_address = '0; req1_wdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) req1_valid = 1'b0;
      else begin
        if (acc1) req1_valid = 1'b0;
        if (!req1_valid && q1.size() > 0) begin
          c = q1.pop_front();
          req1_write = c.wr; req1_address = c.addr; req1_wdata = c.wdata;
          req1_valid = 1'b1;
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
             m_state == 0 && exp_q.size() == 0) && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk(name, 64'(n >= 200), 64'd0);
  endtask

  // Wait until the model reaches a given post-advance state (bounded).
  task automatic wait_model(input string name, input int st);
    int n = 0;
    while (m_state != st && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk(name, 64'(m_state == st), 64'd1);
  endtask

  task automatic pulse_reset(input string name);
    @(negedge clock);
    #1 reset = 1'b1;
    #1 check_all_zero(name);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    bit   exp_grant[6];
    int   snap;

    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    bit   exp_grant[6];
    int   snap;

    tbl[0] = '{id: 0, wr: 1, addr: 4'h9, wdata: 8'hC5, exp_rdata: 8'h00};
    tbl[1] = '{id: 0, wr: 0, addr: 4'h9, wdata: 8'h00, exp_rdata: 8'hC5};
    tbl[2] = '{id: 0, wr: 1, addr: 4'hF, wdata: 8'h09, exp_rdata: 8'h00};
    tbl[3] = '{id: 0, wr: 0, addr: 4'hF, wdata: 8'h00, exp_rdata: 8'h09};
    tbl[4] = '{id: 1, wr: 1, addr: 4'h1, wdata: 8'h0F, exp_rdata: 8'h00};
    tbl[5] = '{id: 1, wr: 0, addr: 4'h1, wdata: 8'h00, exp_rdata: 8'h0F};
    tbl[6] = '{id: 1, wr: 1, addr: 4'h0, wdata: 8'hA3, exp_rdata: 8'h00};
    tbl[7] = '{id: 0, wr: 0, addr: 4'h0, wdata: 8'h00, exp_rdata: 8'hA3};

    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 check_all_zero("reset_outputs");
    reset = 1'b0;

    // Single-requester vectors.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].id) q1.push_back('{wr: tbl[i].wr, addr: tbl[i].addr, wdata: tbl[i].wdata});
      else           q0.push_back('{wr: tbl[i].wr, addr: tbl[i].addr, wdata: tbl[i].wdata});
      snap = rsp_count;
      wait_drain("tbl_drain");
      if (tbl[i].wr) begin
        chk("tbl_we_addr", 64'(last_we_addr), 64'(tbl[i].addr));
        chk("tbl_we_data", 64'(last_we_data), 64'(tbl[i].wdata));
        chk("tbl_store_no_rsp", 64'(rsp_count - snap), 64'd0);
      end else begin
        chk("tbl_rsp_count", 64'(rsp_count - snap), 64'd1);
        chk("tbl_rsp_id", 64'(last_rsp_id), 64'(tbl[i].id));
        chk("tbl_rdata", 64'(last_rsp_data), 64'(tbl[i].exp_rdata));
      end
    end

    // Backpressure: req1 raises valid while a req0 load is in ACCESS.
    q0.push_back('{wr: 0, addr: 4'hF, wdata: 8'h00});
    wait_model("bp_accept", 1);  // DUT idle, accepting at next edge
    q1.push_back('{wr: 0, addr: 4'h9, wdata: 8'h00});
    @(negedge clock);
    #1 chk("bp_ready_access", 64'({req1_valid, req1_ready}), 64'b10);
    @(negedge clock);
    #1 chk("bp_ready_resp", 64'({req1_valid, req1_ready}), 64'b10);
    @(negedge clock);
    #1 chk("bp_ready_idle", 64'({req1_valid, req1_ready}), 64'b11);
    wait_drain("bp_drain");
    chk("bp_rsp_id", 64'(last_rsp_id), 64'd1);
    chk("bp_rdata", 64'(last_rsp_data), 64'hC5);

    // Reset in ACCESS of a load at 0x9 aborts it without a response.
    q0.push_back('{wr: 0, addr: 4'h9, wdata: 8'h00});
    wait_model("rst_reach_access", 2);  // DUT now in ACCESS
    chk("rst_pre_re", 64'(mem_Read_Enable), 64'd1);
    snap = rsp_count;
    reset = 1'b1;
    #1 check_all_zero("rst_midop_outputs");
    repeat (2) @(negedge clock);
    #1 check_all_zero("rst_hold_outputs");
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1 chk("rst_no_rsp", 64'(rsp_count - snap), 64'd0);
    q1.push_back('{wr: 0, addr: 4'h9, wdata: 8'h00});
    wait_drain("rst_after_drain");
    chk("rst_after_count", 64'(rsp_count - snap), 64'd1);
    chk("rst_after_id", 64'(last_rsp_id), 64'd1);
    chk("rst_after_rdata", 64'(last_rsp_data), 64'hC5);

    // Contention: both requesters continuously valid with loads.
    pulse_reset("cont_reset_outputs");
    grant_log.delete();
    foreach (tbl[i]) if (tbl[i].wr) q0.push_back('{wr: 0, addr: tbl[i].addr, wdata: 8'h00});
    q0.push_back('{wr: 0, addr: 4'h9, wdata: 8'h00});
    q0.push_back('{wr: 0, addr: 4'hF, wdata: 8'h00});
    q1.push_back('{wr: 0, addr: 4'h1, wdata: 8'h00});
    q1.push_back('{wr: 0, addr: 4'h0, wdata: 8'h00});
    q1.push_back('{wr: 0, addr: 4'h9, wdata: 8'h00});
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
    exp_grant = '{0, 0, 0, 0, 0, 0};
`else
    exp_grant = '{0, 1, 0, 1, 0, 1};
`endif
    wait_drain("cont_drain");
    chk("cont_grant_count", 64'(grant_log.size()), 64'd9);
    for (int i = 0; i < 6; i++) begin
      if (i < grant_log.size()) chk("cont_grant", 64'(grant_log[i]), 64'(exp_grant[i]));
      else chk("cont_grant_missing", 64'(i), 64'(grant_log.size()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of data words, equal to the Data_Memory data width in CPU_package.
REQ-002 Parameter ADDRESS_WIDTH, default 4: width of word addresses, equal to the Data_Memory address width in CPU_package.
REQ-003 Port clock, input, 1: single clock; it also drives both Data_Memory Write_clock and Read_clock at top level.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports req0_valid / req1_valid, input, 1: requester n presents a command.
REQ-006 Ports req0_write / req1_write, input, 1: 1 = store, 0 = load.
REQ-007 Ports req0_address / req1_address, input, ADDRESS_WIDTH: target word address.
REQ-008 Ports req0_wdata / req1_wdata, input, DATA_WIDTH: store data.
REQ-009 Ports req0_ready / req1_ready, output, 1: the command is accepted when valid and ready are both high at a clock edge.
REQ-010 Ports rsp0_valid / rsp1_valid, output, 1: one-cycle load-data pulse to the requester.
REQ-011 Ports rsp0_rdata / rsp1_rdata, output, DATA_WIDTH: load data, meaningful only while rspN_valid is high.
REQ-012 Ports mem_write_address, mem_Write_Enable, mem_DATA_WRITE, output, ADDRESS_WIDTH/1/DATA_WIDTH: drive the Data_Memory write port.
REQ-013 Ports mem_read_address, mem_Read_Enable, output, ADDRESS_WIDTH/1: drive the Data_Memory read port.
REQ-014 Port mem_DATA_READ, input, DATA_WIDTH: Data_Memory read data, valid the cycle after a clock edge that sampled mem_Read_Enable high.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-016 In IDLE, reqN_ready SHALL be high combinationally only for the arbitration winner among the valid requesters; both ready outputs SHALL be 0 in ACCESS and RESP.
REQ-017 On acceptance, the block SHALL latch the winner id, the write flag, the address and the write data, then go to ACCESS.
REQ-018 In ACCESS, exactly one enable SHALL be high for exactly one cycle:
- Store: mem_Write_Enable=1, with the latched address and data on the write port; next state IDLE.
- Load: mem_Read_Enable=1, with the latched address on mem_read_address; next state RESP.
REQ-019 In RESP, rspN_valid SHALL be 1 for the latched winner only, with rspN_rdata=mem_DATA_READ; next state IDLE.
REQ-020 Latency, counted from the accepting edge:
- Store: occupies 2 cycles.
- Load: rsp pulse occurs in the second cycle after acceptance; total occupancy 3 cycles.
REQ-021 Round-robin: when both requesters are valid in IDLE, the grant SHALL go to the requester not granted last; when only one is valid, that one SHALL be granted.
REQ-022 The last_grant register SHALL update only on acceptance.
REQ-023 A requester SHALL hold valid and its payload stable until accepted; commands are never dropped or reordered.
REQ-024 Outside their active states, mem enables and rspN_valid SHALL be 0; the address and data outputs SHALL hold their latched values.

Reset
REQ-025 While reset is high, the block SHALL immediately and asynchronously:
- Enter IDLE.
- Set last_grant to requester 1, so requester 0 wins the first contention.
- Clear the latched command registers to 0.
- Drive all outputs to 0.
REQ-026 Reset asserted during ACCESS or RESP SHALL abort the in-flight command with no rsp pulse; mem enables SHALL deassert in the same time step.

Configuration
REQ-027 Macro DMEM_ARB_FIXED_PRIORITY_EN controls the arbitration policy:
- Defined: requester 0 always wins contention, and last_grant is unused.
- Undefined: round-robin per REQ-021.

Verification
REQ-028 Store then load at address 0x9: req0 stores 0x9/0xC5 -> mem_Write_Enable pulses 1 cycle with 0x9/0xC5. A subsequent req0 load of 0x9 -> rsp0_valid pulses 2 cycles after acceptance with rsp0_rdata=0xC5, and rsp1_valid stays 0.
REQ-029 Address boundaries: stores 0xF/0x09 and 0x1/0x0F, each followed by a load of the same address -> rdata values 0x09 and 0x0F.
REQ-030 Contention, macro undefined: both requesters continuously valid with loads for 6 commands -> grant order 0,1,0,1,0,1, with ready high only in IDLE cycles.
REQ-031 Contention, macro defined: same stimulus as REQ-030 -> all grants go to req0, and req1 is never ready while req0_valid is high.
REQ-032 Backpressure: req1 asserts valid while a req0 load is in ACCESS -> req1_ready=0 until IDLE, then req1 is accepted.
REQ-033 Reset mid-operation: reset asserted in ACCESS of a load at 0x9 -> mem_Read_Enable=0 immediately, no rsp pulse, and all outputs are 0. After release, a req1 load is served normally.
